// File: rtl/biquad_decim.sv
// biquad_decim: boxcar decimator with an output FIFO for the bi-quad section.
//
// Averages each group of 2^DECIM_LOG2 accepted samples. The result goes into
// a 2^FIFO_LOG2 deep FIFO that drains over a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   nreset     asynchronous active-low reset
//   din        signed filtered sample
//   din_valid  din is valid this cycle
//   clear      synchronous flush of accumulator, phase, FIFO and overflow flag
//   out_data   decimated sample at the FIFO head
//   out_valid  FIFO not empty
//   out_ready  consumer accepts out_data when out_valid && out_ready
//   level      FIFO occupancy, 0..2^FIFO_LOG2
//   overflow   sticky; a result was dropped because the FIFO was full
//
// Optional feature:
//   BIQUAD_DECIM_ROUND_EN  defined   -> round half up before the shift
//                          undefined -> floor truncation
module biquad_decim #(
    parameter int DATAWIDTH  = 16,
    parameter int DECIM_LOG2 = 2,
    parameter int FIFO_LOG2  = 2
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic [DATAWIDTH-1:0] din,
    input  logic                 din_valid,
    input  logic                 clear,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FIFO_LOG2:0]   level,
    output logic                 overflow
);

    localparam int AW    = DATAWIDTH + DECIM_LOG2;
    // A zero-width phase counter is not legal, so keep at least one bit.
    // With DECIM_LOG2 = 0 it simply stays at 0.
    localparam int PW    = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam logic [PW-1:0] PHASE_LAST = PW'((1 << DECIM_LOG2) - 1);

    logic signed [AW-1:0]    acc;
    logic signed [AW-1:0]    din_ext;
    logic signed [AW-1:0]    sum;
    logic [PW-1:0]           phase;
    logic [DATAWIDTH-1:0]    result;

    logic [DATAWIDTH-1:0]    mem [DEPTH];
    logic [FIFO_LOG2:0]      wptr;
    logic [FIFO_LOG2:0]      rptr;
    logic                    full;
    logic                    push_req;
    logic                    push_ok;
    logic                    pop;

    assign din_ext = AW'($signed(din));
    assign sum     = acc + din_ext;

`ifdef BIQUAD_DECIM_ROUND_EN
    // Adding half an LSB of the output before the shift gives round half up.
    // It cannot overflow AW: the sum of M samples is at most M*(2^(W-1)-1).
    localparam logic signed [AW-1:0] RND = AW'((1 << DECIM_LOG2) / 2);
    logic signed [AW-1:0] rsum;
    logic                 unused_rsum_bits;
    assign rsum             = sum + RND;
    assign result           = rsum[AW-1:DECIM_LOG2];
    assign unused_rsum_bits = ^rsum;
`else
    // Dropping the low DECIM_LOG2 bits is an arithmetic shift with floor.
    assign result = sum[AW-1:DECIM_LOG2];
`endif

    // The pointers carry an extra wrap bit. Full means the same slot on a
    // different lap.
    assign full      = (wptr[FIFO_LOG2] != rptr[FIFO_LOG2]) &&
                       (wptr[FIFO_LOG2-1:0] == rptr[FIFO_LOG2-1:0]);
    assign out_valid = (wptr != rptr);
    assign level     = wptr - rptr;
    assign out_data  = mem[rptr[FIFO_LOG2-1:0]];
    assign pop       = out_valid && out_ready;
    assign push_req  = din_valid && (phase == PHASE_LAST);
    // A push into a full FIFO still succeeds when the head is popped on the
    // same edge. The popped slot is the one being overwritten.
    assign push_ok   = push_req && (!full || pop);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            acc   <= '0;
            phase <= '0;
        end else if (clear) begin
            acc   <= '0;
            phase <= '0;
        end else if (din_valid) begin
            // The group wraps even when its result is dropped.
            // This keeps the group alignment.
            if (phase == PHASE_LAST) begin
                acc   <= '0;
                phase <= '0;
            end else begin
                acc   <= sum;
                phase <= phase + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wptr[FIFO_LOG2-1:0]] <= result;
                wptr <= wptr + 1'b1;
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_biquad_decim.sv
// tb_biquad_decim: directed bench for biquad_decim with default parameters.
// A small behavioural model tracks group sums, FIFO occupancy and overflow.
// Expected averages are queued when a group completes. They are compared
// when the DUT hands a sample over.
module tb_biquad_decim;

    logic        clk;
    logic        nreset;
    logic [15:0] din;
    logic        din_valid;
    logic        clear;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;
    logic        overflow;

    int testCount = 0;
    int failCount = 0;

    logic [15:0] sb[$];
    int modelAcc      = 0;
    int modelPhase    = 0;
    int modelLevel    = 0;
    int modelOverflow = 0;

    biquad_decim #(
        .DATAWIDTH (16),
        .DECIM_LOG2(2),
        .FIFO_LOG2 (2)
    ) dut (
        .clk      (clk),
        .nreset   (nreset),
        .din      (din),
        .din_valid(din_valid),
        .clear    (clear),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .level    (level),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference average of a group sum for M = 4.
    function automatic int expectedAvg(input int s);
        int t;
        t = s;
`ifdef BIQUAD_DECIM_ROUND_EN
        t = t + 2;
`endif
        return t >>> 2;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock of stimulus.
    // Inputs are driven at the falling edge and outputs are checked 1ns later.
    // The model is then advanced to reflect the coming rising edge.
    task automatic applyStimulus(input int d, input logic v, input logic r, input logic c);
        logic doPop;
        int   res;
        logic [15:0] resBits;
        logic [15:0] exp;
        @(negedge clk);
        din       = d[15:0];
        din_valid = v;
        out_ready = r;
        clear     = c;
        #1;
        checkOutput("out_valid", 32'(out_valid), 32'(modelLevel != 0));
        checkOutput("level", 32'(level), 32'(modelLevel));
        checkOutput("overflow", 32'(overflow), 32'(modelOverflow));
        doPop = !c && (modelLevel != 0) && r;
        if (doPop) begin
            if (sb.size() == 0) begin
                testCount++;
                failCount++;
                $error("[TB] FAIL sb_underflow observed=%0h expected=none", out_data);
            end else begin
                exp = sb.pop_front();
                checkOutput("out_data", 32'(out_data), 32'(exp));
            end
        end
        if (c) begin
            modelAcc = 0; modelPhase = 0; modelLevel = 0; modelOverflow = 0;
            sb.delete();
        end else begin
            if (v) begin
                modelAcc   = modelAcc + d;
                modelPhase = modelPhase + 1;
                if (modelPhase == 4) begin
                    res = expectedAvg(modelAcc);
                    resBits = res[15:0];
                    modelAcc = 0;
                    modelPhase = 0;
                    if (modelLevel < 4 || doPop) begin
                        sb.push_back(resBits);
                        modelLevel++;
                    end else begin
                        modelOverflow = 1;
                    end
                end
            end
            if (doPop) modelLevel--;
        end
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) applyStimulus(0, 1'b0, r, 1'b0);
    endtask

    task automatic sendGroup(input int d, input logic r);
        for (int i = 0; i < 4; i++) applyStimulus(d, 1'b1, r, 1'b0);
    endtask

    // Hold nreset low with random inputs, checking that everything reads 0.
    // Release with idle inputs.
    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            nreset    = 1'b0;
            din       = 16'($urandom);
            din_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            clear     = 1'($urandom_range(0, 1));
            #1;
            checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
            checkOutput("rst_level", 32'(level), 32'd0);
            checkOutput("rst_overflow", 32'(overflow), 32'd0);
            checkOutput("rst_out_data", 32'(out_data), 32'd0);
        end
        @(negedge clk);
        din = '0; din_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
        nreset = 1'b1;
        modelAcc = 0; modelPhase = 0; modelLevel = 0; modelOverflow = 0;
        sb.delete();
    endtask

    initial begin
        nreset = 1'b0; din = '0; din_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
        doReset(5);

        // No output is expected after three samples.
        applyStimulus(100, 1'b1, 1'b1, 1'b0);
        applyStimulus(200, 1'b1, 1'b1, 1'b0);
        applyStimulus(300, 1'b1, 1'b1, 1'b0);
        applyStimulus(400, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);

        applyStimulus(-1, 1'b1, 1'b1, 1'b0);
        applyStimulus(-1, 1'b1, 1'b1, 1'b0);
        applyStimulus(-1, 1'b1, 1'b1, 1'b0);
        applyStimulus(-2, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Fill the FIFO and overflow it with a fifth group.
        for (int g = 0; g < 5; g++) sendGroup(1000, 1'b0);
        idle(1, 1'b0);
        checkOutput("full_level", 32'(level), 32'd4);
        checkOutput("full_overflow", 32'(overflow), 32'd1);
        idle(6, 1'b1);
        checkOutput("drain_overflow_sticky", 32'(overflow), 32'd1);

        // Push and pop on the same edge into a full FIFO.
        applyStimulus(0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        for (int g = 0; g < 4; g++) sendGroup(1000, 1'b0);
        applyStimulus(1000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1000, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b0);
        checkOutput("pushpop_level", 32'(level), 32'd4);
        checkOutput("pushpop_overflow", 32'(overflow), 32'd0);
        idle(6, 1'b1);

        // Extremes, back-to-back and then with sparse strobes.
        sendGroup(32767, 1'b1);
        sendGroup(-32768, 1'b1);
        idle(2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32767, 1'b1, 1'b1, 1'b0);
            idle(3, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(-32768, 1'b1, 1'b1, 1'b0);
            idle(3, 1'b1);
        end

        // clear in the middle of a group.
        applyStimulus(500, 1'b1, 1'b1, 1'b0);
        applyStimulus(500, 1'b1, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 1'b0, 1'b1);
        sendGroup(8, 1'b1);
        idle(3, 1'b1);
        checkOutput("clear_overflow", 32'(overflow), 32'd0);

        // nreset in the middle of a group.
        applyStimulus(500, 1'b1, 1'b1, 1'b0);
        applyStimulus(500, 1'b1, 1'b1, 1'b0);
        doReset(3);
        sendGroup(8, 1'b1);
        idle(3, 1'b1);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);

        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/biquad_decim.md
Name: biquad_decim

Overview:
- Downstream consumer of the bi-quad IIR filter section output.
- Accepts one filtered sample per input strobe and averages each group of 2^DECIM_LOG2 consecutive samples (boxcar decimation).
- Buffers the decimated results in a small FIFO and presents them to the next stage (packetiser or register bank) over a valid/ready handshake.
- Decouples the filter's sample-rate pacing from a consumer that may stall.

Parameters:
- DATAWIDTH, 16: width of input and output samples, signed fractional 2's complement.
- DECIM_LOG2, 2: log2 of decimation ratio M; legal range 0..8 (M = 1..256).
- FIFO_LOG2, 2: log2 of output FIFO depth; legal range 1..6 (default depth 4).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- nreset  in  1  asynchronous active-low reset.
- din  in  DATAWIDTH  filtered sample; connects to the filter output.
- din_valid  in  1  din is valid this cycle; driven by the filter's valid strobe delayed one clock to align with its registered output.
- clear  in  1  synchronous flush of accumulator, phase, FIFO and overflow flag.
- out_data  out  DATAWIDTH  decimated sample at FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready.
- level  out  FIFO_LOG2+1  current FIFO occupancy, 0..2^FIFO_LOG2.
- overflow  out  1  sticky; a decimated result was dropped because the FIFO was full.

Behaviour:
- Reset: nreset low clears all state asynchronously.
  - Accumulator and phase are 0.
  - FIFO pointers are 0; out_valid = 0, level = 0, overflow = 0.
  - out_data = 0 (FIFO storage cleared).
- Accumulator: signed, DATAWIDTH+DECIM_LOG2 bits; din is sign-extended before adding. It cannot overflow.
- Phase counter: DECIM_LOG2 bits, counts accepted samples modulo M.
- Each cycle with din_valid = 1 and clear = 0:
  - If phase < M-1: acc <= acc + din; phase <= phase + 1.
  - If phase == M-1: result = (acc + din) >>> DECIM_LOG2, arithmetic shift with floor truncation and the low DATAWIDTH bits kept. The result cannot exceed the input range. Push result to FIFO; acc <= 0; phase <= 0.
  - If DECIM_LOG2 = 0, every valid sample is pushed unchanged.
- Cycles with din_valid = 0 leave acc and phase unchanged. There is no minimum spacing between strobes; back-to-back strobes are legal.
- FIFO:
  - Depth 2^FIFO_LOG2, circular read/write pointers with an extra wrap bit.
  - out_data is read combinationally from storage at the read pointer.
  - out_valid = level != 0.
- Latency: a result pushed at edge N has out_valid = 1 after edge N when the FIFO was empty.
- Pop: on an edge where out_valid && out_ready, the read pointer advances.
  - out_ready while empty has no effect.
- Full and push:
  - Without a simultaneous pop, the result is discarded, overflow <= 1 and the pointers are unchanged.
  - Phase and acc still wrap, so group alignment is kept.
- Full with simultaneous push and pop: both succeed; level stays at max and overflow is not set.
- Empty with simultaneous push and pop: no pop occurs (out_valid was 0); the push succeeds and level = 1.
- Pointer wrap: pointers wrap modulo 2^(FIFO_LOG2+1); full and empty are decoded from the MSB and the remaining bits.
- clear = 1 at an edge:
  - acc <= 0, phase <= 0, FIFO emptied, overflow <= 0.
  - Any din_valid and pop in that cycle are ignored.
  - clear has priority over all other updates.
- nreset asserted mid-group or mid-handshake: state is lost with no partial output. After release, the first accepted sample starts a new group at phase 0.
- overflow is cleared only by nreset or clear.

Optional Feature:
- Macro: BIQUAD_DECIM_ROUND_EN.
- Defined: result = (acc + din + 2^(DECIM_LOG2-1)) >>> DECIM_LOG2, i.e. round half up. This still cannot exceed the input range. There is no effect when DECIM_LOG2 = 0.
- Undefined: floor truncation as specified in Behaviour.
- Ports and latency are identical in both builds.

Test Plan (defaults DATAWIDTH=16, DECIM_LOG2=2, FIFO_LOG2=2):
- Reset: hold nreset low with random inputs -> out_valid=0, level=0, overflow=0, out_data=0; release -> outputs remain 0 until 4 valids have been accepted.
- Average: out_ready=1, din=100,200,300,400 on consecutive valids -> out_data=250 with out_valid=1 the cycle after the 4th valid edge; popped next edge, level returns to 0.
- Negative truncation: din=-1,-1,-1,-2 -> out_data=-2 (0xFFFE); with BIQUAD_DECIM_ROUND_EN -> -1 (0xFFFF).
- Full/overflow:
  - out_ready=0; 5 groups of 4x1000 -> level=4, overflow=1, fifth group dropped.
  - Then out_ready=1 -> four pops of 1000, level=0, overflow stays 1.
  - Repeat with a pop in the same cycle as the fifth push -> overflow stays 0, level=4.
- Extremes: 4x32767 -> 32767; 4x(-32768) -> -32768; with sparse valids (gaps of 3 clocks) -> same results.
- clear/reset mid-group: 2 valids of 500, pulse clear, then 4x8 -> single output of 8 and overflow=0. Repeat using nreset instead of clear -> same.
